hmmm_mem_if: RTL and testbench

Memory interface stage sitting directly downstream of the microcoded control unit. It owns the MAR and MDR and turns the control strobes `mar_in`, `mdr_in` and `mdr_out` into single-outstanding read/write transactions on an external 256×16 RAM port (req/ack handshake). It drives MDR contents onto the internal 16-bit bus and raises `busy` so the control unit can hold its microcode step until data is valid.

---
 rtl/hmmm_pkg.sv | 17 +
 rtl/mem_timeout.sv | 41 ++++
 rtl/hmmm_mem_if.sv | 143 ++++++++++++++
 tb/tb_hmmm_mem_if.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/hmmm_pkg.sv
// Shared types and sizes for the Hmmm memory interface stage.
package hmmm_pkg;

    localparam int HMMM_ADDR_W = 8;
    localparam int HMMM_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } hmmm_state_e;

    function automatic logic any_strobe(input logic a, input logic b, input logic c);
        return a | b | c;
    endfunction

endpackage

// File: rtl/mem_timeout.sv
// Loadable down-counter bounding how long a memory request may wait for its ack.
module mem_timeout #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic clear,
    output logic expired
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             active_r;

    // Count register: loads on start, walks down to zero while a request waits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r    <= {CNT_W{1'b0}};
            active_r <= 1'b0;
        end else if (clear) begin
            cnt_r    <= {CNT_W{1'b0}};
            active_r <= 1'b0;
        end else if (start) begin
            cnt_r    <= LOAD_VAL;
            active_r <= 1'b1;
        end else if (active_r && (cnt_r != {CNT_W{1'b0}})) begin
            cnt_r    <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            active_r <= active_r;
        end else begin
            cnt_r    <= cnt_r;
            active_r <= active_r;
        end
    end

    // Zero count while armed marks the last permitted waiting cycle.
    assign expired = active_r && (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/hmmm_mem_if.sv
// MAR/MDR owner translating control-unit strobes into single-outstanding
// req/ack transactions on the external RAM port.
module hmmm_mem_if
    import hmmm_pkg::*;
#(
    parameter int ADDR_W  = HMMM_ADDR_W,
    parameter int DATA_W  = HMMM_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_drive,
    input  logic              mar_in,
    input  logic              mdr_in,
    input  logic              mdr_out,
    output logic              busy,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    hmmm_state_e       state_r, state_s;
    logic [ADDR_W-1:0] mar_r, mar_s;
    logic [DATA_W-1:0] mdr_r, mdr_s;
    logic              err_r, err_s;
    logic              busy_r, req_r, we_r;
    logic              tmo_start_s, tmo_clear_s, tmo_expired_s;

    mem_timeout #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (8)
    ) u_mem_timeout (
        .clk     (clk),
        .rst     (rst),
        .start   (tmo_start_s),
        .clear   (tmo_clear_s),
        .expired (tmo_expired_s)
    );

    // Next-state, register-update and error decisions.
    always_comb begin
        state_s     = state_r;
        mar_s       = mar_r;
        mdr_s       = mdr_r;
        err_s       = err_r;
        tmo_start_s = 1'b0;
        tmo_clear_s = 1'b0;
        case (state_r)
            IDLE: begin
                // Combined strobe is a write to the new address; no read is issued.
                if (mar_in && mdr_in) begin
                    mar_s       = bus_in[ADDR_W-1:0];
                    mdr_s       = bus_in;
                    state_s     = WRITE;
                    tmo_start_s = 1'b1;
                end else if (mar_in) begin
                    mar_s       = bus_in[ADDR_W-1:0];
                    state_s     = READ;
                    tmo_start_s = 1'b1;
                end else if (mdr_in) begin
                    mdr_s       = bus_in;
                    state_s     = WRITE;
                    tmo_start_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            READ: begin
                if (mem_ack) begin
                    mdr_s       = mem_rdata;
                    state_s     = IDLE;
                    tmo_clear_s = 1'b1;
                end else if (tmo_expired_s) begin
                    state_s     = IDLE;
                    err_s       = 1'b1;
                    tmo_clear_s = 1'b1;
                end else begin
                    state_s = READ;
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    state_s     = IDLE;
                    tmo_clear_s = 1'b1;
                end else if (tmo_expired_s) begin
                    state_s     = IDLE;
                    err_s       = 1'b1;
                    tmo_clear_s = 1'b1;
                end else begin
                    state_s = WRITE;
                end
            end
            default: begin
                state_s     = IDLE;
                tmo_clear_s = 1'b1;
            end
        endcase

        // Strobes during a transaction are dropped but flagged.
        if ((state_r != IDLE) && any_strobe(mar_in, mdr_in, mdr_out)) begin
            err_s = 1'b1;
        end else begin
            err_s = err_s;
        end
    end

    // State, address/data and status registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
            mar_r   <= {ADDR_W{1'b0}};
            mdr_r   <= {DATA_W{1'b0}};
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
            req_r   <= 1'b0;
            we_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            mar_r   <= mar_s;
            mdr_r   <= mdr_s;
            err_r   <= err_s;
            busy_r  <= (state_s != IDLE);
            req_r   <= (state_s != IDLE);
            we_r    <= (state_s == WRITE);
        end
    end

    assign busy      = busy_r;
    assign err       = err_r;
    assign mem_req   = req_r;
    assign mem_we    = we_r;
    assign mem_addr  = mar_r;
    assign mem_wdata = mdr_r;
    assign bus_out   = mdr_r;
    assign bus_drive = mdr_out && !busy_r;

endmodule

// File: tb/tb_hmmm_mem_if.sv
// Scoreboard bench for hmmm_mem_if: a bench-side RAM model answers requests,
// expected transactions and read data are queued when strobes are driven.
module tb_hmmm_mem_if;

    typedef struct packed {
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bus_in;
    logic [15:0] bus_out;
    logic        bus_drive;
    logic        mar_in, mdr_in, mdr_out;
    logic        busy, err;
    logic        mem_req, mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic        mem_ack;

    int          n_checks = 0;
    int          n_errors = 0;

    logic [15:0] mem_m [256];
    logic [7:0]  mar_m;
    logic [15:0] mdr_m;
    txn_t        txn_q[$];
    logic [15:0] rd_q[$];

    always #5 clk = ~clk;

    hmmm_mem_if #(
        .ADDR_W  (8),
        .DATA_W  (16),
        .TIMEOUT (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_in    (bus_in),
        .bus_out   (bus_out),
        .bus_drive (bus_drive),
        .mar_in    (mar_in),
        .mdr_in    (mdr_in),
        .mdr_out   (mdr_out),
        .busy      (busy),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Strobe, then act as the RAM: hold for `waits` cycles, ack, update model.
    task automatic run_txn(input logic m_in, input logic d_in, input logic [15:0] val,
                           input int waits, input logic d_out);
        txn_t exp;
        txn_t t;
        mar_in = m_in;
        mdr_in = d_in;
        bus_in = val;
        if (d_out) begin
            mdr_out = 1'b1;
            #1;
            check_eq("drive_old", {31'd0, bus_drive}, 32'd1);
            check_eq("old_mdr", {16'd0, bus_out}, {16'd0, mdr_m});
        end
        if (m_in) mar_m = val[7:0];
        if (d_in) mdr_m = val;
        t.we = d_in; t.addr = mar_m; t.wdata = mdr_m;
        txn_q.push_back(t);
        if (!d_in) rd_q.push_back(mem_m[mar_m]);
        @(negedge clk);
        mar_in = 1'b0; mdr_in = 1'b0; mdr_out = 1'b0;
        check_eq("busy_rise", {31'd0, busy}, 32'd1);
        exp = txn_q.pop_front();
        for (int i = 0; i <= waits; i++) begin
            check_eq("req", {31'd0, mem_req}, 32'd1);
            check_eq("we", {31'd0, mem_we}, {31'd0, exp.we});
            check_eq("addr", {24'd0, mem_addr}, {24'd0, exp.addr});
            check_eq("wdata", {16'd0, mem_wdata}, {16'd0, exp.wdata});
            if (i == waits) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_m[exp.addr];
            end
            @(negedge clk);
        end
        mem_ack   = 1'b0;
        mem_rdata = 16'h0000;
        check_eq("busy_fall", {31'd0, busy}, 32'd0);
        check_eq("req_fall", {31'd0, mem_req}, 32'd0);
        if (exp.we) mem_m[exp.addr] = exp.wdata;
        else        mdr_m = mem_m[exp.addr];
    endtask

    // Put MDR on the bus for a moment; compare with queued read data or the model.
    task automatic show_mdr(input string tag, input logic from_q);
        logic [15:0] e;
        mdr_out = 1'b1;
        #1;
        check_eq({tag, "_drive"}, {31'd0, bus_drive}, 32'd1);
        if (from_q) begin
            if (rd_q.size() == 0) begin
                check_eq({tag, "_rdq_empty"}, 32'd0, 32'd1);
                e = mdr_m;
            end else begin
                e = rd_q.pop_front();
            end
        end else begin
            e = mdr_m;
        end
        check_eq(tag, {16'd0, bus_out}, {16'd0, e});
        mdr_out = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        mar_m = 8'h00;
        mdr_m = 16'h0000;
        rd_q.delete();
        txn_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem_m[i] = (16'(i) * 16'h0101) ^ 16'h5A5A;
        mem_m[8'h12] = 16'hBEEF;
        rst = 1'b0; bus_in = 16'h0; mar_in = 1'b0; mdr_in = 1'b0; mdr_out = 1'b0;
        mem_rdata = 16'h0; mem_ack = 1'b0;
        mar_m = 8'h00; mdr_m = 16'h0000;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_req", {31'd0, mem_req}, 32'd0);
        check_eq("rst_err", {31'd0, err}, 32'd0);
        check_eq("rst_drive", {31'd0, bus_drive}, 32'd0);
        check_eq("rst_mar", {24'd0, mem_addr}, 32'd0);
        check_eq("rst_mdr", {16'd0, bus_out}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        show_mdr("idle_mdr0", 1'b0);

        run_txn(1'b1, 1'b0, 16'h0012, 0, 1'b0);
        show_mdr("rd_beef", 1'b1);
        run_txn(1'b1, 1'b0, 16'h0040, 0, 1'b0);
        show_mdr("rd_40", 1'b1);
        run_txn(1'b0, 1'b1, 16'h1234, 3, 1'b0);
        check_eq("wr_err", {31'd0, err}, 32'd0);
        run_txn(1'b1, 1'b1, 16'h00A5, 1, 1'b0);
        run_txn(1'b1, 1'b0, 16'h00A5, 0, 1'b0);
        show_mdr("rd_a5", 1'b1);
        run_txn(1'b0, 1'b1, 16'h5555, 2, 1'b1);
        run_txn(1'b1, 1'b0, 16'h00A5, 0, 1'b0);
        show_mdr("rd_5555", 1'b1);
        run_txn(1'b1, 1'b0, 16'h0040, 1, 1'b0);
        show_mdr("rd_1234", 1'b1);
        check_eq("pre_tmo_err", {31'd0, err}, 32'd0);

        // No ack: request stays up exactly TIMEOUT cycles.
        mar_in = 1'b1; bus_in = 16'h0020; mar_m = 8'h20;
        @(negedge clk);
        mar_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("tmo_req", {31'd0, mem_req}, 32'd1);
            @(negedge clk);
        end
        check_eq("tmo_busy", {31'd0, busy}, 32'd0);
        check_eq("tmo_err", {31'd0, err}, 32'd1);
        check_eq("tmo_addr", {24'd0, mem_addr}, 32'h20);
        show_mdr("tmo_mdr", 1'b0);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check_eq("idle_ack_busy", {31'd0, busy}, 32'd0);
        show_mdr("idle_ack_mdr", 1'b0);
        do_reset();
        check_eq("rst2_err", {31'd0, err}, 32'd0);

        // Reset while a read is outstanding, then a stale ack.
        mar_in = 1'b1; bus_in = 16'h0033;
        @(negedge clk);
        mar_in = 1'b0;
        check_eq("mid_req", {31'd0, mem_req}, 32'd1);
        do_reset();
        check_eq("mid_req_drop", {31'd0, mem_req}, 32'd0);
        check_eq("mid_mar", {24'd0, mem_addr}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 16'h0000;
        check_eq("late_ack_busy", {31'd0, busy}, 32'd0);
        check_eq("late_ack_err", {31'd0, err}, 32'd0);
        show_mdr("late_ack_mdr", 1'b0);

        // Strobes during a read of 0x10 are ignored but flagged.
        mar_in = 1'b1; bus_in = 16'h0010; mar_m = 8'h10;
        @(negedge clk);
        mar_in = 1'b1; bus_in = 16'h0077; mdr_out = 1'b1;
        #1;
        check_eq("busy_nodrive", {31'd0, bus_drive}, 32'd0);
        @(negedge clk);
        mar_in = 1'b0; mdr_out = 1'b0;
        check_eq("busy_mar", {24'd0, mem_addr}, 32'h10);
        check_eq("busy_err", {31'd0, err}, 32'd1);
        mem_ack = 1'b1; mem_rdata = mem_m[8'h10];
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 16'h0000;
        mdr_m = mem_m[8'h10];
        check_eq("busy_done", {31'd0, busy}, 32'd0);
        check_eq("busy_mar_kept", {24'd0, mem_addr}, 32'h10);
        show_mdr("busy_rd", 1'b0);
        repeat (3) @(negedge clk);
        check_eq("err_sticky", {31'd0, err}, 32'd1);
        do_reset();
        check_eq("err_cleared", {31'd0, err}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
